// File: rtl/frame_blit_if.sv
// Handshake and data bundle between the piece-movement FSM (master) and the
// frame blitter (slave).
interface frame_blit_if #(
  parameter int unsigned ROWS  = 22,
  parameter int unsigned COLS  = 10,
  parameter int unsigned FRAME = 5,
  parameter int unsigned CW    = 3
);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned CLW = $clog2(COLS);

  logic                                 start;
  logic [1:0]                           mode;
  logic [RW-1:0]                        row_inx;
  logic [CLW-1:0]                       col_inx;
  logic [FRAME-1:0][FRAME-1:0][CW-1:0]  n_frame;
  logic [ROWS-1:0][COLS-1:0][CW-1:0]    grid_in;
  logic [ROWS-1:0][COLS-1:0][CW-1:0]    n_grid;
  logic                                 busy;
  logic                                 done;
  logic                                 collide;
  logic                                 oob;

  modport master (
    output start, mode, row_inx, col_inx, n_frame, grid_in,
    input  n_grid, busy, done, collide, oob
  );

  modport slave (
    input  start, mode, row_inx, col_inx, n_frame, grid_in,
    output n_grid, busy, done, collide, oob
  );
endinterface

// File: rtl/frame_blit.sv
// Sequential blitter: stamps a FRAMExFRAME piece into the playfield one cell per clock.
// Optional FRAME_BLIT_EARLY_EXIT_EN: CHECK mode stops at the first collide/oob hit.
module frame_blit #(
  parameter int unsigned ROWS  = 22,
  parameter int unsigned COLS  = 10,
  parameter int unsigned FRAME = 5,
  parameter int unsigned CW    = 3
) (
  input logic       clk,
  input logic       rst,
  frame_blit_if.slave bus
);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CLW   = $clog2(COLS);
  localparam int unsigned FW    = $clog2(FRAME);
  localparam int unsigned Cells = FRAME * FRAME;
  localparam int unsigned CntW  = $clog2(Cells);

  localparam logic [1:0] ModeOver  = 2'd0;
  localparam logic [1:0] ModeMerge = 2'd1;
  localparam logic [1:0] ModeErase = 2'd2;
  localparam logic [1:0] ModeCheck = 2'd3;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  typedef logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_t;
  typedef logic [FRAME-1:0][FRAME-1:0][CW-1:0] frame_t;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  frame_t         frame_q, frame_d;
  grid_t          grid_q, grid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           collide_q, collide_d;
  logic           oob_q, oob_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [FW-1:0]  fi, fj;
  logic [RW:0]    r;
  logic [CLW:0]   c;
  logic           inb;
  logic [CW-1:0]  f, g;
  logic           hit_oob, hit_col, last, accept, early;

  // Current scan cell; r/c are one bit wider so a frame hanging off the edge never wraps.
  always_comb begin
    fi      = FW'(cnt_q / CntW'(FRAME));
    fj      = FW'(cnt_q % CntW'(FRAME));
    r       = (RW+1)'(row_q) + (RW+1)'(fi);
    c       = (CLW+1)'(col_q) + (CLW+1)'(fj);
    inb     = (r < (RW+1)'(ROWS)) && (c < (CLW+1)'(COLS));
    f       = frame_q[fi][fj];
    g       = inb ? grid_q[r[RW-1:0]][c[CLW-1:0]] : '0;
    hit_oob = !inb && (f != '0);
    hit_col = inb && (f != '0) && (g != '0) &&
              ((mode_q == ModeMerge) || (mode_q == ModeCheck));
    last    = (cnt_q == CntW'(Cells - 1));
    // A start landing on the done-pulse cycle is deliberately dropped.
    accept  = (state_q == StIdle) && bus.start && !done_q;
`ifdef FRAME_BLIT_EARLY_EXIT_EN
    early   = (mode_q == ModeCheck) && (hit_oob || hit_col);
`else
    early   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= ModeOver;
      row_q     <= '0;
      col_q     <= '0;
      frame_q   <= '0;
      grid_q    <= '0;
      cnt_q     <= '0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      row_q     <= row_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
      grid_q    <= grid_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
      oob_q     <= oob_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StScan;
      StScan:  if (last || early) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    row_d     = row_q;
    col_d     = col_q;
    frame_d   = frame_q;
    grid_d    = grid_q;
    cnt_d     = cnt_q;
    collide_d = collide_q;
    oob_d     = oob_q;
    done_d    = (state_q == StDone);
    busy_d    = (state_d != StIdle);
    case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d    = bus.mode;
          row_d     = bus.row_inx;
          col_d     = bus.col_inx;
          frame_d   = bus.n_frame;
          grid_d    = bus.grid_in;
          cnt_d     = '0;
          collide_d = 1'b0;
          oob_d     = 1'b0;
        end
      end
      StScan: begin
        if (hit_oob) oob_d = 1'b1;
        if (hit_col) collide_d = 1'b1;
        if (inb) begin
          case (mode_q)
            ModeOver:  grid_d[r[RW-1:0]][c[CLW-1:0]] = f;
            ModeMerge: if (f != '0) grid_d[r[RW-1:0]][c[CLW-1:0]] = f;
            ModeErase: if (f != '0) grid_d[r[RW-1:0]][c[CLW-1:0]] = '0;
            default:   ;
          endcase
        end
        if (!last) cnt_d = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  assign bus.n_grid  = grid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.collide = collide_q;
  assign bus.oob     = oob_q;
endmodule

// File: tb/tb_frame_blit.sv
// Directed vector bench for frame_blit: a table of blit jobs plus reset/abort,
// done-cycle start and early-exit sequences.
module tb_frame_blit;
  localparam int unsigned ROWS  = 22;
  localparam int unsigned COLS  = 10;
  localparam int unsigned FRAME = 5;
  localparam int unsigned CW    = 3;
  localparam int NV = 7;

  typedef logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_t;
  typedef logic [FRAME-1:0][FRAME-1:0][CW-1:0] frame_t;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] row;
    logic [3:0] col;
    frame_t     frame;
    grid_t      gin;
    grid_t      gexp;
    logic       exp_col;
    logic       exp_oob;
    int         exp_lat;
  } vec_t;

  vec_t v[NV];
  vec_t ve;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;
  logic saw_done;

  frame_blit_if #(.ROWS(ROWS), .COLS(COLS), .FRAME(FRAME), .CW(CW)) bus ();

  frame_blit #(.ROWS(ROWS), .COLS(COLS), .FRAME(FRAME), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_grid(input string nm, input grid_t act, input grid_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int l);
    logic got;
    got = 1'b0;
    l   = 999;
    for (int k = 1; k <= 100; k++) begin
      if (!got) begin
        @(posedge clk);
        #1;
        if (bus.done) begin
          got = 1'b1;
          l   = k;
        end
      end
    end
  endtask

  task automatic drive(input vec_t x);
    bus.mode    = x.mode;
    bus.row_inx = x.row;
    bus.col_inx = x.col;
    bus.n_frame = x.frame;
    bus.grid_in = x.gin;
  endtask

  // Scrambles inputs mid-scan; the result must depend only on the latched job.
  task automatic corrupt(input vec_t x);
    bus.n_frame = '1;
    bus.grid_in = ~x.gin;
    bus.mode    = ~x.mode;
    bus.row_inx = '0;
    bus.col_inx = '0;
  endtask

  task automatic check_result(input vec_t x, input string tag, input int l);
    chk({tag, " latency"}, l, x.exp_lat);
    chk_grid({tag, " n_grid"}, bus.n_grid, x.gexp);
    chk({tag, " collide"}, bus.collide, x.exp_col);
    chk({tag, " oob"}, bus.oob, x.exp_oob);
  endtask

  task automatic run_vec(input vec_t x, input string tag);
    int l;
    drive(x);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    corrupt(x);
    chk({tag, " busy after start"}, bus.busy, 1);
    wait_done(l);
    check_result(x, tag, l);
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, bus.done, 0);
    chk({tag, " busy idle"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    ve = '{default: '0};
    ve.mode = 2'd0;
    drive(ve);

    for (int i = 0; i < NV; i++) begin
      v[i] = '{default: '0};
      v[i].exp_lat = 26;
    end

    // 0: OVERWRITE all-7 frame at (0,0) onto an empty grid.
    v[0].mode  = 2'd0;
    v[0].frame = {FRAME*FRAME{3'd7}};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) v[0].gexp[r][c] = 3'd7;

    // 1: MERGE I-piece at (10,3), colliding with [12][5]=4.
    v[1].mode = 2'd1;
    v[1].row  = 5'd10;
    v[1].col  = 4'd3;
    for (int j = 0; j < 4; j++) v[1].frame[2][j] = 3'd1;
    v[1].gin[12][5] = 3'd4;
    for (int c = 3; c <= 6; c++) v[1].gexp[12][c] = 3'd1;
    v[1].exp_col = 1'b1;

    // 2: CHECK at (20,8), frame[2][2] lands on row 22.
    v[2].mode = 2'd3;
    v[2].row  = 5'd20;
    v[2].col  = 4'd8;
    v[2].frame[2][2] = 3'd3;
    v[2].gin[12][5]  = 3'd4;
    v[2].gexp        = v[2].gin;
    v[2].exp_oob     = 1'b1;

    // 3: ERASE I-piece at (10,3) with occupied neighbours.
    v[3].mode  = 2'd2;
    v[3].row   = 5'd10;
    v[3].col   = 4'd3;
    v[3].frame = v[1].frame;
    for (int c = 3; c <= 6; c++) v[3].gin[12][c] = 3'd1;
    v[3].gin[12][2] = 3'd6;
    v[3].gin[11][4] = 3'd2;
    v[3].gin[13][6] = 3'd5;
    v[3].gin[12][7] = 3'd3;
    v[3].gexp[12][2] = 3'd6;
    v[3].gexp[11][4] = 3'd2;
    v[3].gexp[13][6] = 3'd5;
    v[3].gexp[12][7] = 3'd3;

    // 4: OVERWRITE clipped at bottom-right; empty cells clear, [4][4] is oob.
    v[4].mode = 2'd0;
    v[4].row  = 5'd19;
    v[4].col  = 4'd7;
    v[4].frame[0][0] = 3'd2;
    v[4].frame[4][4] = 3'd3;
    for (int r = 19; r <= 21; r++)
      for (int c = 7; c <= 9; c++) v[4].gin[r][c] = 3'd5;
    v[4].gin[0][0]   = 3'd1;
    v[4].gin[18][7]  = 3'd4;
    v[4].gexp[19][7] = 3'd2;
    v[4].gexp[0][0]  = 3'd1;
    v[4].gexp[18][7] = 3'd4;
    v[4].exp_oob     = 1'b1;

    // 5: MERGE last frame cell into the last grid cell, no collision.
    v[5].mode = 2'd1;
    v[5].row  = 5'd17;
    v[5].col  = 4'd5;
    v[5].frame[4][4] = 3'd6;
    v[5].gin[21][8]  = 3'd1;
    v[5].gexp[21][8] = 3'd1;
    v[5].gexp[21][9] = 3'd6;

    // 6: CHECK at the last cell: collide at [21][9], then oob at column 10.
    v[6].mode = 2'd3;
    v[6].row  = 5'd21;
    v[6].col  = 4'd9;
    v[6].frame[0][0] = 3'd4;
    v[6].frame[0][1] = 3'd4;
    v[6].gin[21][9]  = 3'd7;
    v[6].gexp        = v[6].gin;
    v[6].exp_col     = 1'b1;
    v[6].exp_oob     = 1'b1;

`ifdef FRAME_BLIT_EARLY_EXIT_EN
    v[2].exp_lat = 14;
    v[6].exp_lat = 2;
    v[6].exp_oob = 1'b0;
`endif

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk_grid("reset n_grid", bus.n_grid, '0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset collide", bus.collide, 0);
    chk("reset oob", bus.oob, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(v[i], $sformatf("v%0d", i));
      after_done($sformatf("v%0d", i));
    end

    // Start held through the done cycle is dropped, then taken on the next idle cycle.
    run_vec(v[5], "dc_pre");
    drive(v[1]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("start on done cycle ignored", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    corrupt(v[1]);
    chk("start after done cycle taken", bus.busy, 1);
    wait_done(lat);
    check_result(v[1], "dc", lat);
    after_done("dc");

    // Abort: second start at scan cycle 5 ignored, reset at cycle 10.
    drive(v[0]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    saw_done  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
      if (k == 4) bus.start = 1'b1;
      if (k == 5) begin
        bus.start = 1'b0;
        chk("busy through ignored start", bus.busy, 1);
      end
      if (k == 9) rst = 1'b1;
    end
    rst = 1'b0;
    chk("abort no done", saw_done, 0);
    chk_grid("abort n_grid", bus.n_grid, '0);
    chk("abort busy", bus.busy, 0);
    chk("abort oob", bus.oob, 0);
    run_vec(v[0], "post_abort");
    after_done("post_abort");

`ifdef FRAME_BLIT_EARLY_EXIT_EN
    ve = '{default: '0};
    ve.mode = 2'd3;
    ve.frame[0][1] = 3'd2;
    ve.gin[0][1]   = 3'd3;
    ve.gexp        = ve.gin;
    ve.exp_col     = 1'b1;
    ve.exp_lat     = 3;
    run_vec(ve, "early");
    after_done("early");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
